// File: rtl/adc_pid_controller.sv
// Sample-at-a-time PID controller: six-cycle FSM that turns one ADC code into a clamped 12-bit output.
// Optional derivative term is enabled by defining ADC_PID_DERIV_EN; when it is undefined, d is forced to 0.
module adc_pid_controller #(
    parameter int OUT_MAX = 4095,
    parameter int INTEG_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sample_in,
    input  logic        sample_valid,
    input  logic [11:0] setpoint,
    input  logic [7:0]  kp,
    input  logic [7:0]  ki,
    input  logic [7:0]  kd,
    output logic [11:0] u_out,
    output logic        u_valid,
    output logic        sat,
    output logic        busy
);

    localparam int SW = INTEG_W + 3;
    localparam logic signed [INTEG_W:0] IMAX      = {2'b00, {(INTEG_W - 1){1'b1}}};
    localparam logic signed [INTEG_W:0] IMIN      = -IMAX;
    localparam logic signed [SW-1:0]    OUT_MAX_S = SW'(OUT_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_PTERM, S_ITERM, S_DTERM, S_SUM
    } state_t;

    state_t                     state_q, state_d;
    logic [11:0]                sample_q, sample_d;
    logic [11:0]                setpoint_q, setpoint_d;
    logic [7:0]                 kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
    logic signed [12:0]         e_q, e_d, e_prev_q, e_prev_d;
    logic signed [13:0]         de_q, de_d;
    logic signed [21:0]         p_q, p_d;
    logic signed [INTEG_W-1:0]  integ_q, integ_d;
    logic signed [22:0]         d_q, d_d;
    logic [11:0]                u_out_q, u_out_d;
    logic                       u_valid_q, u_valid_d;
    logic                       sat_q, sat_d, sat_hi_q, sat_hi_d;

    logic signed [21:0]         e_ext22, kp_ext, ki_ext, p_prod, i_prod;
    logic signed [22:0]         d_prod;
    logic signed [12:0]         e_new;
    logic signed [INTEG_W:0]    integ_sum;
    logic signed [SW-1:0]       sum_full, s_val;
    logic                       windup_hold;

    assign e_ext22 = {{9{e_q[12]}}, e_q};
    assign kp_ext  = {14'b0, kp_q};
    assign ki_ext  = {14'b0, ki_q};
    assign p_prod  = kp_ext * e_ext22;
    assign i_prod  = ki_ext * e_ext22;

`ifdef ADC_PID_DERIV_EN
    logic signed [22:0] kd_ext, de_ext;
    assign kd_ext = {15'b0, kd_q};
    assign de_ext = {{9{de_q[13]}}, de_q};
    assign d_prod = kd_ext * de_ext;
`else
    logic unused_deriv;
    assign d_prod       = '0;
    assign unused_deriv = ^{kd_q, de_q};
`endif

    // Integrator freezes while the output is pinned and the error pushes further into that same limit.
    assign windup_hold = sat_q && ((sat_hi_q && (e_q > 13'sd0)) || (!sat_hi_q && (e_q < 13'sd0)));

    assign e_new     = $signed({1'b0, setpoint_q}) - $signed({1'b0, sample_q});
    assign integ_sum = {integ_q[INTEG_W-1], integ_q} + {{(INTEG_W - 21){i_prod[21]}}, i_prod};
    assign sum_full  = {{(SW - 22){p_q[21]}}, p_q}
                     + {{3{integ_q[INTEG_W-1]}}, integ_q}
                     + {{(SW - 23){d_q[22]}}, d_q};
    assign s_val     = sum_full >>> 4;

    // NOTE: every _d gets a default of its _q first, so no branch can leave a value unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        setpoint_d = setpoint_q;
        kp_d       = kp_q;
        ki_d       = ki_q;
        kd_d       = kd_q;
        e_d        = e_q;
        e_prev_d   = e_prev_q;
        de_d       = de_q;
        p_d        = p_q;
        integ_d    = integ_q;
        d_d        = d_q;
        u_out_d    = u_out_q;
        u_valid_d  = 1'b0;
        sat_d      = sat_q;
        sat_hi_d   = sat_hi_q;

        unique case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    sample_d   = sample_in;
                    setpoint_d = setpoint;
                    kp_d       = kp;
                    ki_d       = ki;
                    kd_d       = kd;
                    state_d    = S_ERR;
                end
            end
            S_ERR: begin
                e_d      = e_new;
                de_d     = {e_new[12], e_new} - {e_prev_q[12], e_prev_q};
                e_prev_d = e_new;
                state_d  = S_PTERM;
            end
            S_PTERM: begin
                p_d     = p_prod;
                state_d = S_ITERM;
            end
            S_ITERM: begin
                if (!windup_hold) begin
                    if (integ_sum > IMAX) begin
                        integ_d = IMAX[INTEG_W-1:0];
                    end else if (integ_sum < IMIN) begin
                        integ_d = IMIN[INTEG_W-1:0];
                    end else begin
                        integ_d = integ_sum[INTEG_W-1:0];
                    end
                end
                state_d = S_DTERM;
            end
            S_DTERM: begin
                d_d     = d_prod;
                state_d = S_SUM;
            end
            S_SUM: begin
                u_valid_d = 1'b1;
                if (s_val < 0) begin
                    u_out_d  = 12'd0;
                    sat_d    = 1'b1;
                    sat_hi_d = 1'b0;
                end else if (s_val > OUT_MAX_S) begin
                    u_out_d  = 12'(OUT_MAX);
                    sat_d    = 1'b1;
                    sat_hi_d = 1'b1;
                end else begin
                    u_out_d  = s_val[11:0];
                    sat_d    = 1'b0;
                    sat_hi_d = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: operand capture registers are not reset; they are always written on acceptance before being read.
    always_ff @(posedge clk) begin
        sample_q   <= sample_d;
        setpoint_q <= setpoint_d;
        kp_q       <= kp_d;
        ki_q       <= ki_d;
        kd_q       <= kd_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            e_q       <= '0;
            e_prev_q  <= '0;
            de_q      <= '0;
            p_q       <= '0;
            integ_q   <= '0;
            d_q       <= '0;
            u_out_q   <= '0;
            u_valid_q <= 1'b0;
            sat_q     <= 1'b0;
            sat_hi_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            e_q       <= e_d;
            e_prev_q  <= e_prev_d;
            de_q      <= de_d;
            p_q       <= p_d;
            integ_q   <= integ_d;
            d_q       <= d_d;
            u_out_q   <= u_out_d;
            u_valid_q <= u_valid_d;
            sat_q     <= sat_d;
            sat_hi_q  <= sat_hi_d;
        end
    end

    assign u_out   = u_out_q;
    assign u_valid = u_valid_q;
    assign sat     = sat_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_pid_controller.sv
// Self-checking bench for adc_pid_controller: vector table with scoreboard, plus abort/ignore sequences.
module tb_adc_pid_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic [11:0] setpoint;
    logic [7:0]  kp, ki, kd;
    logic [11:0] u_out;
    logic        u_valid;
    logic        sat;
    logic        busy;

    adc_pid_controller dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .setpoint     (setpoint),
        .kp           (kp),
        .ki           (ki),
        .kd           (kd),
        .u_out        (u_out),
        .u_valid      (u_valid),
        .sat          (sat),
        .busy         (busy)
    );

    always #5 clk = ~clk;

`ifdef ADC_PID_DERIV_EN
    localparam logic [11:0] DERIV_FIRST = 12'd500;
`else
    localparam logic [11:0] DERIV_FIRST = 12'd0;
`endif

    typedef struct {
        bit          do_rst;
        logic [11:0] sp;
        logic [11:0] smp;
        logic [7:0]  kp;
        logic [7:0]  ki;
        logic [7:0]  kd;
        logic [11:0] exp_u;
        bit          exp_sat;
    } vec_t;

    typedef struct {
        logic [11:0] u;
        logic        s;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[15];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_uvalid = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every u_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (u_valid) begin
            n_uvalid++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_u_valid: got pulse with u_out=%0d, required none", u_out);
            end else begin
                e = sb_q.pop_front();
                check("u_out", u_out, e.u);
                check("sat", sat, e.s);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_sample(input vec_t v);
        exp_t e;
        setpoint     = v.sp;
        sample_in    = v.smp;
        kp           = v.kp;
        ki           = v.ki;
        kd           = v.kd;
        sample_valid = 1'b1;
        e.u = v.exp_u;
        e.s = v.exp_sat;
        sb_q.push_back(e);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("busy_cycle%0d", c), busy, 1);
            check($sformatf("u_valid_low_cycle%0d", c), u_valid, 0);
            @(posedge clk); #1;
        end
        check("busy_cycle6", busy, 0);
        check("u_valid_cycle6", u_valid, 1);
    endtask

    initial begin
        int start_cnt;

        vecs[0]  = '{1'b1, 12'd2048, 12'd2048, 8'd16,  8'd0,   8'd0,  12'd0,    1'b0};
        vecs[1]  = '{1'b1, 12'd3000, 12'd1000, 8'd16,  8'd0,   8'd0,  12'd2000, 1'b0};
        vecs[2]  = '{1'b1, 12'd4095, 12'd0,    8'd255, 8'd0,   8'd0,  12'd4095, 1'b1};
        vecs[3]  = '{1'b0, 12'd0,    12'd4095, 8'd16,  8'd0,   8'd0,  12'd0,    1'b1};
        vecs[4]  = '{1'b1, 12'd1100, 12'd1000, 8'd0,   8'd16,  8'd0,  12'd100,  1'b0};
        vecs[5]  = '{1'b0, 12'd1100, 12'd1000, 8'd0,   8'd16,  8'd0,  12'd200,  1'b0};
        vecs[6]  = '{1'b0, 12'd1100, 12'd1000, 8'd0,   8'd16,  8'd0,  12'd300,  1'b0};
        vecs[7]  = '{1'b1, 12'd1500, 12'd1000, 8'd0,   8'd0,   8'd16, DERIV_FIRST, 1'b0};
        vecs[8]  = '{1'b0, 12'd1500, 12'd1000, 8'd0,   8'd0,   8'd16, 12'd0,    1'b0};
        vecs[9]  = '{1'b1, 12'd2000, 12'd1000, 8'd24,  8'd0,   8'd0,  12'd1500, 1'b0};
        vecs[10] = '{1'b1, 12'd1500, 12'd1000, 8'd8,   8'd4,   8'd0,  12'd375,  1'b0};
        // Wind the integrator into the top clamp, then one opposing sample must bring it back to exactly 0.
        vecs[11] = '{1'b1, 12'd4095, 12'd0,    8'd0,   8'd255, 8'd0,  12'd4095, 1'b1};
        vecs[12] = '{1'b0, 12'd4095, 12'd0,    8'd0,   8'd255, 8'd0,  12'd4095, 1'b1};
        vecs[13] = '{1'b0, 12'd4095, 12'd0,    8'd0,   8'd255, 8'd0,  12'd4095, 1'b1};
        vecs[14] = '{1'b0, 12'd0,    12'd4095, 8'd0,   8'd255, 8'd0,  12'd0,    1'b0};

        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        setpoint     = '0;
        kp           = '0;
        ki           = '0;
        kd           = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_u_out", u_out, 0);
        check("reset_u_valid", u_valid, 0);
        check("reset_sat", sat, 0);
        check("reset_busy", busy, 0);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].do_rst) do_reset();
            run_sample(vecs[i]);
        end
        @(posedge clk); #1;

        // A strobe in cycle 3 must be dropped: one pulse, result from the first sample only.
        do_reset();
        start_cnt = n_uvalid;
        run_sample_ignore();
        repeat (12) @(posedge clk);
        #1;
        check("ignore_single_u_valid", n_uvalid - start_cnt, 1);
        check("ignore_u_out_held", u_out, 4095);
        check("ignore_sat_held", sat, 1);

        // Reset in cycle 3 aborts the sample: outputs cleared and no pulse afterwards.
        start_cnt    = n_uvalid;
        setpoint     = 12'd3000;
        sample_in    = 12'd1000;
        kp           = 8'd16;
        ki           = 8'd0;
        kd           = 8'd0;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_u_out", u_out, 0);
        check("abort_sat", sat, 0);
        check("abort_busy", busy, 0);
        check("abort_u_valid", u_valid, 0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_u_valid", n_uvalid - start_cnt, 0);

        run_sample('{1'b0, 12'd3000, 12'd1000, 8'd16, 8'd0, 8'd0, 12'd2000, 1'b0});
        @(posedge clk); #1;
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic run_sample_ignore();
        exp_t e;
        setpoint     = 12'd4095;
        sample_in    = 12'd0;
        kp           = 8'd255;
        ki           = 8'd0;
        kd           = 8'd0;
        sample_valid = 1'b1;
        e.u = 12'd4095;
        e.s = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        setpoint     = 12'd3000;
        sample_in    = 12'd1000;
        kp           = 8'd16;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        check("ignore_busy_cycle4", busy, 1);
    endtask

endmodule

// File: doc/adc_pid_controller.md
ADC_PID_CONTROLLER -- requirements
Module: adc_pid_controller

Interface
REQ-001 SHALL have parameter OUT_MAX, default 4095, upper clamp of u_out.
REQ-002 SHALL have parameter INTEG_W, default 24, signed integrator width in bits.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port sample_in  in  12  unsigned ADC code, sampled only on acceptance.
REQ-006 SHALL have port sample_valid  in  1  one-cycle strobe marking a new ADC code.
REQ-007 SHALL have port setpoint  in  12  unsigned target code, sampled on acceptance.
REQ-008 SHALL have ports kp, ki, kd  in  8 each  unsigned Q4.4 gains, sampled on acceptance.
REQ-009 SHALL have port u_out  out  12  unsigned control output, held between updates.
REQ-010 SHALL have port u_valid  out  1  one-cycle pulse when u_out updates.
REQ-011 SHALL have port sat  out  1  high when the last u_out was clamped.
REQ-012 SHALL have port busy  out  1  high while a sample is in process.

Function
REQ-013 SHALL use FSM IDLE->ERR->PTERM->ITERM->DTERM->SUM->IDLE, one state per cycle.
REQ-014 SHALL accept a sample only in IDLE with sample_valid=1, registering sample_in, setpoint and gains.
REQ-015 SHALL ignore sample_valid while busy=1, with no queuing.
REQ-016 SHALL assert busy from the cycle after acceptance through SUM, i.e. cycles 1..5 if acceptance is cycle 0.
REQ-017 SHALL pulse u_valid in cycle 6 for exactly one cycle, with busy=0 in cycle 6; sample_valid in cycle 6 SHALL be accepted.
REQ-018 SHALL compute in ERR: e = setpoint - sample (13-bit signed) and de = e - e_prev; SHALL then set e_prev = e.
REQ-019 SHALL compute in PTERM: p = kp*e (signed, 22-bit minimum).
REQ-020 SHALL compute in ITERM: integ += ki*e, saturating at +/-(2^(INTEG_W-1)-1).
REQ-021 SHALL hold integ unchanged when sat=1 and the sign of e drives further into the active limit (anti-windup).
REQ-022 SHALL compute in DTERM: d = kd*de.
REQ-023 SHALL compute in SUM: s = (p + integ + d) arithmetically shifted right by 4.
REQ-024 SHALL clamp s to [0, OUT_MAX] into u_out; sat=1 iff a clamp occurred; u_out and sat SHALL update only with u_valid.

Reset
REQ-025 SHALL, on rst=1 at any edge including mid-computation, set state=IDLE, u_out=0, u_valid=0, sat=0, busy=0, integ=0 and e_prev=0.
REQ-026 SHALL produce no u_valid for a sample aborted by reset.
REQ-027 SHALL take de = e for the first sample after reset, since e_prev=0.

Configuration
REQ-028 SHALL compute d as in REQ-022 when macro ADC_PID_DERIV_EN is defined.
REQ-029 SHALL force d=0 when ADC_PID_DERIV_EN is undefined; kd SHALL be ignored and the DTERM state SHALL remain, keeping latency at 6.

Verification
REQ-030 SHALL cover: setpoint=2048, sample=2048, kp=16, ki=kd=0 -> cycle 6 u_valid=1, u_out=0, sat=0.
REQ-031 SHALL cover: setpoint=3000, sample=1000, kp=16, ki=kd=0 -> u_out=2000, sat=0.
REQ-032 SHALL cover: setpoint=4095, sample=0, kp=255 -> u_out=4095, sat=1; then setpoint=0, sample=4095, kp=16 -> u_out=0, sat=1.
REQ-033 SHALL cover: setpoint=1100, sample=1000, kp=0, ki=16, three samples -> u_out=100, 200, 300.
REQ-034 SHALL cover: kp=ki=0, kd=16, setpoint=1500, sample=1000 twice -> with ADC_PID_DERIV_EN u_out=500 then 0; without it, 0 then 0.
REQ-035 SHALL cover: sample_valid again in cycle 3 -> ignored, single u_valid at cycle 6; rst in cycle 3 -> no u_valid, all outputs 0.
